// File: rtl/pill_count_display.sv
// pill_count_display: converts the 10-bit pill count to BCD with a sequential
// double-dabble engine and scans the result onto a 4-digit seven-segment display.
module pill_count_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  countp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic        busy
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SCAN_MAX = SW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        state_q;
  logic [9:0]    cap_q;
  logic [9:0]    bin_q;
  logic [9:0]    last_q;
  logic [15:0]   work_q;
  logic [3:0]    step_q;
  logic [15:0]   bcd_q;
  logic          bcd_valid_q;
  logic          busy_q;

  logic [SW-1:0] scan_q;
  logic [1:0]    dig_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic [1:0]    msd_d;
  logic [3:0]    nib_d;
  logic          blank_d;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [15:0] add3(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    for (int i = 0; i < 4; i++) begin
      if (w[4*i +: 4] >= 4'd5) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} code for one decimal digit; non-decimal blanks.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Converter FSM: capture on a count change, 10 shift steps, then commit.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      bin_q       <= '0;
      last_q      <= '0;
      work_q      <= '0;
      step_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (countp != last_q) begin
            cap_q   <= countp;
            bin_q   <= countp;
            work_q  <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {work_q, bin_q} <= {add3(work_q), bin_q} << 1;
          step_q          <= step_q + 4'd1;
          if (step_q == 4'd9) state_q <= COMMIT;
        end
        COMMIT: begin
          bcd_q       <= work_q;
          last_q      <= cap_q;
          bcd_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pick the nibble for the current digit and decide leading-zero blanking.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    msd_d = 2'd0;
    if (bcd_q[15:12] != 4'd0)     msd_d = 2'd3;
    else if (bcd_q[11:8] != 4'd0) msd_d = 2'd2;
    else if (bcd_q[7:4] != 4'd0)  msd_d = 2'd1;
    nib_d   = bcd_q[{dig_q, 2'b00} +: 4];
    blank_d = (dig_q > msd_d);
  end

  // Free-running scan: hold each digit REFRESH_DIV cycles, drive registered an/seg.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      dig_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
    end else begin
      if (scan_q == SCAN_MAX) begin
        scan_q <= '0;
        dig_q  <= dig_q + 2'd1;
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      an_q  <= ~(4'b0001 << dig_q);
      seg_q <= blank_d ? 7'b1111111 : seg_code(nib_d);
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pill_count_display.sv
// Bench for pill_count_display: every cycle is compared against a behavioural
// model built from decimal arithmetic and a conversion timeline; a vector table
// and hand-written sequences add explicit expectations for the key scenarios.
module tb_pill_count_display;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  countp = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pill_count_display #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .countp(countp),
    .an(an), .seg(seg), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Reference model state.
  int          k;         // clock edges since reset release
  bit          m_active;  // a conversion is in flight
  int          m_t;       // edges since capture
  int          m_cap;
  int          m_last;
  int          m_val;     // committed decimal value
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [15:0] m_bcd;
  logic        m_valid;
  logic        m_busy;
  int          p10[4] = '{1, 10, 100, 1000};

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int dig;
    if (rst) begin
      k = 0; m_active = 0; m_t = 0; m_cap = 0; m_last = 0; m_val = 0;
      m_an = 4'b1111; m_seg = 7'b1111111; m_bcd = '0; m_valid = 0; m_busy = 0;
    end else begin
      dig  = (k / R) % 4;
      m_an = ~(4'b0001 << dig);
      if (dig == 0 || m_val >= p10[dig]) m_seg = seg_of((m_val / p10[dig]) % 10);
      else                               m_seg = 7'b1111111;
      k++;
      m_valid = 0;
      if (!m_active) begin
        if (int'(countp) != m_last) begin
          m_active = 1; m_cap = int'(countp); m_t = 0; m_busy = 1;
        end
      end else begin
        m_t++;
        if (m_t == 11) begin
          m_val = m_cap; m_bcd = to_bcd(m_cap); m_last = m_cap;
          m_valid = 1; m_busy = 0; m_active = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("an", an, m_an);
    check("seg", seg, m_seg);
    check("bcd", bcd, m_bcd);
    check("bcd_valid", bcd_valid, m_valid);
    check("busy", busy, m_busy);
  endtask

  // One full frame: each lit digit must show its expected pattern.
  task automatic frame_check(input string name, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    for (int i = 0; i < 4 * R; i++) begin
      tick();
      case (an)
        4'b1110: check({name, "_units"}, seg, e0);
        4'b1101: check({name, "_tens"}, seg, e1);
        4'b1011: check({name, "_hundreds"}, seg, e2);
        4'b0111: check({name, "_thousands"}, seg, e3);
        default: check({name, "_an_onehot"}, an, 4'b1110);
      endcase
    end
  endtask

  typedef struct {
    logic [9:0]  cp;
    logic [15:0] exp_bcd;
    logic [6:0]  s0, s1, s2, s3;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   lat, busy_n, pulses;
    bit   got;
    logic [15:0] first_bcd, second_bcd;

    vecs[0] = '{10'd1,    16'h0001, 7'b1111001, 7'h7F,      7'h7F,      7'h7F};
    vecs[1] = '{10'd999,  16'h0999, 7'b0010000, 7'b0010000, 7'b0010000, 7'h7F};
    vecs[2] = '{10'd1023, 16'h1023, 7'b0110000, 7'b0100100, 7'b1000000, 7'b1111001};
    vecs[3] = '{10'd0,    16'h0000, 7'b1000000, 7'h7F,      7'h7F,      7'h7F};
    vecs[4] = '{10'd512,  16'h0512, 7'b0100100, 7'b1111001, 7'b0010010, 7'h7F};
    vecs[5] = '{10'd80,   16'h0080, 7'b1000000, 7'b0000000, 7'h7F,      7'h7F};
    vecs[6] = '{10'd7,    16'h0007, 7'b1111000, 7'h7F,      7'h7F,      7'h7F};

    // Reset values.
    rst = 1'b1; countp = '0;
    repeat (3) tick();
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_bcd", bcd, 16'h0000);
    check("rst_valid", bcd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);

    // First cycle after release, then an idle frame with blanking.
    rst = 1'b0;
    tick();
    check("post_rst_an", an, 4'b1110);
    check("post_rst_seg", seg, 7'b1000000);
    frame_check("idle0", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);
    check("idle_busy", busy, 1'b0);

    // Table: latency, busy length, committed value and displayed frame.
    for (int v = 0; v < 7; v++) begin
      countp = vecs[v].cp;
      lat = 0; busy_n = 0; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        lat++;
        if (busy) busy_n++;
        if (bcd_valid) got = 1;
      end
      check("valid_seen", got, 1'b1);
      check("latency", lat, 12);
      check("busy_cycles", busy_n, 11);
      check("vec_bcd", bcd, vecs[v].exp_bcd);
      tick();
      check("valid_one_cycle", bcd_valid, 1'b0);
      frame_check("vec_frame", vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3);
    end

    // Change 5 -> 37 three cycles into the conversion of 5.
    countp = 10'd5;
    tick();
    repeat (3) tick();
    countp = 10'd37;
    pulses = 0; first_bcd = '0; second_bcd = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bcd_valid) begin
        pulses++;
        if (pulses == 1) first_bcd = bcd;
        if (pulses == 2) second_bcd = bcd;
      end
    end
    check("chg_pulses", pulses, 2);
    check("chg_first", first_bcd, 16'h0005);
    check("chg_second", second_bcd, 16'h0037);

    // Reset during SHIFT cycle 5 of a conversion of 512.
    countp = 10'd512;
    tick();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_an", an, 4'b1111);
    check("midrst_seg", seg, 7'b1111111);
    check("midrst_bcd", bcd, 16'h0000);
    check("midrst_valid", bcd_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    got = 0; lat = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      lat++;
      if (bcd_valid) got = 1;
    end
    check("midrst_valid_seen", got, 1'b1);
    check("midrst_latency", lat, 12);
    check("midrst_bcd_after", bcd, 16'h0512);

    // Randomized counts, hold times and occasional resets against the model.
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      countp = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
